// File: rtl/fp_wire.sv
// fp_wire: payload and record types for fp_vec_writer, plus the record packing helper.
package fp_wire;
  localparam int REC_W = 156;
  localparam int REC_D1_LSB = 124;
  localparam int REC_D2_LSB = 92;
  localparam int REC_D3_LSB = 60;
  localparam int REC_RES_LSB = 28;
  localparam int REC_FLAGS_LSB = 20;
  localparam int REC_RM_LSB = 16;
  localparam int REC_OP_LSB = 12;
  localparam int REC_OPCODE_LSB = 0;
  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] data3;
    logic [2:0]  rm;
    logic [1:0]  op;
    logic [9:0]  opcode;
  } fp_vec_entry;
  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] data3;
    logic [31:0] result;
    logic [2:0]  pad0;
    logic [4:0]  flags;
    logic        pad1;
    logic [2:0]  rm;
    logic [1:0]  pad2;
    logic [1:0]  op;
    logic [1:0]  pad3;
    logic [9:0]  opcode;
  } fp_vec_record;
  function automatic fp_vec_record make_record(fp_vec_entry e, logic [31:0] result, logic [4:0] flags);
    logic [REC_W-1:0] r;
    r = '0;
    r[REC_D1_LSB +: 32] = e.data1;
    r[REC_D2_LSB +: 32] = e.data2;
    r[REC_D3_LSB +: 32] = e.data3;
    r[REC_RES_LSB +: 32] = result;
    r[REC_FLAGS_LSB +: 5] = flags;
    r[REC_RM_LSB +: 3] = e.rm;
    r[REC_OP_LSB +: 2] = e.op;
    r[REC_OPCODE_LSB +: 10] = e.opcode;
    return fp_vec_record'(r);
  endfunction
endpackage

// File: rtl/fp_vec_writer_fifo.sv
// fp_vec_fifo: synchronous circular FIFO with same-cycle push/pop and occupancy count.
module fp_vec_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rp];
  always_ff @(posedge clock)
    if (do_push) mem[wp] <= wdata;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fp_vec_writer.sv
// fp_vec_writer: pairs issued fp_unit operations with their results into 156-bit vector records.
module fp_vec_writer import fp_wire::*; #(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic [31:0]            iss_data1,
  input  logic [31:0]            iss_data2,
  input  logic [31:0]            iss_data3,
  input  logic [2:0]             iss_rm,
  input  logic [1:0]             iss_op,
  input  logic [9:0]             iss_opcode,
  input  logic                   res_valid,
  input  logic [31:0]            res_result,
  input  logic [4:0]             res_flags,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [155:0]           rec_data,
  output logic [31:0]            rec_count,
  output logic                   err_underflow,
  output logic                   err_overflow,
  output logic [$clog2(DEPTH):0] inflight
);
  fp_vec_entry entry, head;
  fp_vec_record rec_q;
  logic full, empty, pop, load, drain;
  assign entry = {iss_data1, iss_data2, iss_data3, iss_rm, iss_op, iss_opcode};
  assign iss_ready = ~full;
  assign pop = res_valid & ~empty;
  assign drain = rec_valid & rec_ready;
  assign load = pop & (~rec_valid | rec_ready);
  assign rec_data = rec_q;
  fp_vec_fifo #(.W($bits(fp_vec_entry)), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(iss_valid),
    .pop(pop),
    .wdata(entry),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(inflight)
  );
  // A result that cannot be loaded still pops so later results stay aligned with their issues.
  always_ff @(posedge clock) begin
    if (reset) begin
      rec_valid <= 1'b0;
      rec_q <= '0;
      rec_count <= '0;
      err_underflow <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      rec_valid <= load | (rec_valid & ~rec_ready);
      if (load) rec_q <= make_record(head, res_result, res_flags);
      if (drain) rec_count <= rec_count + 32'd1;
      if (res_valid & empty) err_underflow <= 1'b1;
      if (pop & ~load) err_overflow <= 1'b1;
    end
  end
endmodule

// File: doc/fp_vec_writer.md
# fp_vec_writer

Synthesizable capture block that sits on the execute interface of `fp_unit` and turns each issued operation plus its returned result and flags into one 156-bit test-vector record. Records use the same bit layout the floating-point vector benches consume from `fpu.dat`, so a golden file can be regenerated from silicon or from a trusted model. Operand and opcode context is held in an in-flight FIFO until the matching `ready` pulse arrives. Finished records leave through a valid/ready stream port toward a trace memory or UART dumper.

## Interface
- `DEPTH`, 8: in-flight FIFO entries, power of two, ≥2; also bounds `fp_unit` latency × issue rate.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `iss_valid`  in  1  operation issued to `fp_unit` this cycle, mirrors `fp_exe_i.enable`.
- `iss_ready`  out  1  FIFO can accept an issue; `~full`.
- `iss_data1`, `iss_data2`, `iss_data3`  in  32 each  operands.
- `iss_rm`  in  3  rounding mode.
- `iss_op`  in  2  conversion sub-op (`fcvt_op`).
- `iss_opcode`  in  10  one-hot opcode vector: bit0 fmadd, 1 fadd, 2 fsub, 3 fmul, 4 fdiv, 5 fsqrt, 6 fcmp, 8 fcvt_i2f, 9 fcvt_f2i.
- `res_valid`  in  1  `fp_exe_o.ready`.
- `res_result`  in  32  `fp_exe_o.result`.
- `res_flags`  in  5  `fp_exe_o.flags`.
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  sink accepts the record.
- `rec_data`  out  156  packed record.
- `rec_count`  out  32  records accepted by the sink; wraps.
- `err_underflow`  out  1  sticky: result arrived with no entry in flight.
- `err_overflow`  out  1  sticky: result arrived while the output register was held.
- `inflight`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Issue: on `iss_valid & iss_ready`, push {data1, data2, data3, rm, op, opcode}. Issue while full is dropped and does not set an error; the upstream driver must honour `iss_ready`.
- Result: on `res_valid`:
  - If the FIFO is non-empty, pop the head and form the record.
  - If the FIFO is empty, set `err_underflow` and produce no record. A push in the same cycle does not satisfy the result, because the push lands at the end of the cycle.
- Record layout:
  - [155:124] data1, [123:92] data2, [91:60] data3, [59:28] result.
  - [27:25] 0, [24:20] flags, [19] 0, [18:16] rm.
  - [15:14] 0, [13:12] op, [11:10] 0, [9:0] opcode.
- Output register: a single entry.
  - Load it when a record is formed and the register is empty, or is being drained this cycle (`rec_valid & rec_ready`).
  - Otherwise the new record is lost, `err_overflow` is set, and the FIFO head is still popped to keep alignment.
- `rec_count` increments on every `rec_valid & rec_ready`.
- FIFO: circular, read/write pointers wrap at `DEPTH`. Push and pop in the same cycle are allowed at any occupancy, including full (pop side) and empty (underflow rule above).
- Error flags clear only on reset.

## Timing
- Reset values: `rec_valid` 0, `rec_data` 0, `rec_count` 0, `err_*` 0, `inflight` 0, `iss_ready` 1.
- Latency: `res_valid` at cycle t gives `rec_valid` at t+1. Back-to-back results give one record per cycle while `rec_ready` stays high.
- `iss_ready` and `inflight` are registered state. A push at t is visible in `inflight` at t+1.
- `rec_data` holds steady while `rec_valid & ~rec_ready`.
- `reset` asserted mid-stream discards the FIFO contents and any pending record in the cycle it is sampled. Results arriving after reset release with no new issue set `err_underflow`.

## Structure
- Put the following in `fp_wire`:
  - `fp_vec_entry` packed struct holding the FIFO payload.
  - `fp_vec_record` packed struct, 156 bits, in the layout above.
  - Localparams for the field bit positions.
- One sub-module, `fp_vec_fifo`: a generic synchronous FIFO with parameterised width and depth, full/empty/count outputs, and same-cycle push and pop. The top level holds the output register, the error flags and the counter.

## Test plan
- Issue fadd with data1 0x3F800000, data2 0x40000000 and rm 000; return `res_result` 0x40400000 with flags 00000 three cycles later. Expect `rec_data` = {3F800000, 40000000, 00000000, 40400000, 0000000, opcode 0x002} one cycle after `res_valid`, and `rec_count` 1.
- Issue 8 ops back-to-back with `DEPTH`=8. `iss_ready` must drop after the 8th. Return 8 results in order: the records must match issue order, and `inflight` must return to 0.
- Hold `rec_ready` low and send two results. The first record must stay held, `err_overflow` must be 1, and `inflight` must decrement by 2.
- Assert `res_valid` with the FIFO empty while `iss_valid` is high in the same cycle. Expect `err_underflow` 1, no record, and `inflight` 1.
- Assert reset with 3 ops in flight and `rec_valid` high. Next cycle all outputs must equal their reset values; `err_*` stay 0 until a stray result arrives.
